vector_load_unit: RTL and testbench
===================================

# vector_load_unit

Sequential writer for the 8-entry × 256-bit vector register file. On a start pulse it fetches 16 consecutive 16-bit words from data memory over a ready-qualified read interface and packs them into one 256-bit vector. It then issues a single-cycle write to the register file using its `wr_dst`/`wr_data`/`wr_en` write port. It sits between the decode/issue stage (vector-load instructions) and the vector register file.

## Interface
Parameters:
- `LANES`, 16, number of 16-bit elements per vector
- `LANE_W`, 16, element width in bits
- `ADDR_W`, 16, memory address width

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load; sampled only in IDLE
- `base_addr`  in  ADDR_W  address of lane 0
- `dst`  in  3  destination vector register
- `busy`  out  1  high in every state other than IDLE
- `done`  out  1  one-cycle pulse, coincident with `wr_en`
- `mem_rd_en`  out  1  read request, held high while in FETCH
- `mem_addr`  out  ADDR_W  address of the current lane
- `mem_rdy`  in  1  `mem_data` is valid this cycle for `mem_addr`
- `mem_data`  in  LANE_W  returned element
- `wr_en`  out  1  register-file write strobe
- `wr_dst`  out  3  register-file write index
- `wr_data`  out  LANES*LANE_W  packed vector; lane i occupies bits [i*LANE_W +: LANE_W]

## Operation
- FSM states: IDLE, FETCH, WRITE.
- **IDLE → FETCH** when `start` = 1.
  - Latch `base_addr` and `dst`.
  - Clear lane index `idx` to 0.
- **FETCH**
  - `mem_rd_en` = 1.
  - `mem_addr` = `base_addr` + `idx`·stride, computed modulo 2^ADDR_W (wraps silently).
  - On each cycle with `mem_rdy` = 1, store `mem_data` into lane `idx` and increment `idx`.
  - When the store of lane LANES-1 occurs, go to WRITE.
  - With `mem_rdy` = 0, stay in FETCH; the address is unchanged and the request is held.
- **WRITE**
  - `wr_en` = 1 and `done` = 1 for exactly one cycle.
  - `wr_dst` = latched `dst`; `wr_data` = assembled buffer.
  - Then return to IDLE.
- `start` while `busy` is ignored; it is not queued.
- `base_addr` and `dst` changes after acceptance have no effect.
- Outputs in IDLE: `busy`, `mem_rd_en`, `wr_en`, `done` = 0; `mem_addr` = 0.
- `wr_data` holds the last assembled vector; it is meaningful only when `wr_en` = 1.
- `wr_dst` holds the last latched value.

## Timing
- All outputs are functions of registered state only; there is no combinational path from `mem_rdy` to the outputs.
- Start accepted at edge 0:
  - FETCH spans cycles 1..N, where N ≥ LANES.
  - WRITE occurs in cycle N+1.
- Minimum latency from `start` to `wr_en` is LANES+1 = 17 cycles, when `mem_rdy` is held high.
- `busy` rises the cycle after `start` is accepted and falls the cycle after WRITE.
- A new `start` may be accepted in the first IDLE cycle after WRITE.
- Reset at any edge:
  - Next state is IDLE; `idx`, the buffer, and the latched fields are cleared.
  - `wr_data` = 0 and `wr_dst` = 0.
  - No `wr_en` is issued for the aborted load.
- Reset has priority over `start` and `mem_rdy` in the same cycle.

## Configuration
- `VLOAD_STRIDE_EN` defined:
  - Adds input `stride` (ADDR_W), latched together with `base_addr`.
  - Lane i is read from `base_addr` + i·`stride` mod 2^ADDR_W.
  - `stride` = 0 replicates one element across all lanes.
- `VLOAD_STRIDE_EN` undefined:
  - The `stride` port is absent; stride is fixed at 1 (unit-stride loads only).

## Structure
- Shared package `vec_pkg` holds:
  - `LANES`, `LANE_W`, `VREG_W` (256), `VREG_IDX_W` (3).
  - The FSM state enum `vload_state_t`.
  - The lane-slice helper used by all vector blocks.
- One sub-module, `vector_lane_assembler`, holds:
  - The LANES×LANE_W buffer with indexed lane write and synchronous clear.
  - The FSM, counter, and address generation stay in `vector_load_unit`.

## Test plan
- **Unit-stride load:** reset; `start`, `base_addr`=0x0100, `dst`=5, `mem_rdy`=1, memory returns word 0x1000+i at address 0x0100+i → single `wr_en` at cycle 17, `wr_dst`=5, lane i = 0x1000+i, `done` coincident.
- **Stalled memory:** `mem_rdy` low on every other cycle → `mem_addr` held during stalls, write at cycle 33 with correct data, exactly 16 accepted lanes.
- **Address wrap:** `base_addr`=0xFFF8 → addresses 0xFFF8..0xFFFF then 0x0000..0x0007; lane 8 is the word at 0x0000.
- **Start while busy:** `start` pulsed at cycles 3 and 10 with other `dst`/`base_addr` → ignored; one write to the original `dst`.
- **Reset mid-FETCH:** `rst` at cycle 9 → IDLE next cycle, no `wr_en` ever, `busy`=0; a fresh load afterward completes correctly.
- **Strided load (`VLOAD_STRIDE_EN`):** `stride`=4, `base_addr`=0x0200 → addresses 0x0200, 0x0204, …, 0x023C; `stride`=0 → all lanes equal the word at 0x0200.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath blocks: register-file geometry,
// the vector-load FSM state type and the lane-slice helper.
package vec_pkg;

  localparam int LANES      = 16;
  localparam int LANE_W     = 16;
  localparam int VREG_W     = LANES * LANE_W;
  localparam int VREG_IDX_W = 3;

  typedef enum logic [1:0] {
    VL_IDLE  = 2'd0,
    VL_FETCH = 2'd1,
    VL_WRITE = 2'd2
  } vload_state_t;

  // Extract lane 'lane' from a packed vector (lane i at bits [i*LANE_W +: LANE_W]).
  function automatic logic [LANE_W-1:0] lane_slice(input logic [VREG_W-1:0] vec,
                                                   input int unsigned lane);
    return vec[lane*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/vector_lane_assembler.sv
// Lane buffer for the vector load unit: LANES registers of LANE_W bits, one
// written per accepted memory word, cleared synchronously on reset. The
// packed view of the buffer is presented continuously on vec_out.
module vector_lane_assembler #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lane_we,
  input  logic [IDX_W-1:0]        lane_idx,
  input  logic [LANE_W-1:0]       lane_data,
  output logic [LANES*LANE_W-1:0] vec_out
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] lane_reg;

      // Capture the returned word when this lane is the one being filled.
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (lane_we && (lane_idx == IDX_W'(gi))) begin
          lane_reg <= lane_data;
        end
      end

      assign vec_out[gi*LANE_W +: LANE_W] = lane_reg;
    end
  endgenerate

endmodule

// File: rtl/vector_load_unit.sv
// Vector load unit: fetches LANES consecutive (or strided) LANE_W-bit words
// over a ready-qualified read port, packs them into one vector and issues a
// single-cycle register-file write.
// Optional feature macro: VLOAD_STRIDE_EN adds a 'stride' input latched with
// base_addr; without it every load is unit-stride.
module vector_load_unit #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr,
`ifdef VLOAD_STRIDE_EN
  input  logic [ADDR_W-1:0]                 stride,
`endif
  input  logic [vec_pkg::VREG_IDX_W-1:0]    dst,
  output logic                              busy,
  output logic                              done,
  output logic                              mem_rd_en,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic                              mem_rdy,
  input  logic [LANE_W-1:0]                 mem_data,
  output logic                              wr_en,
  output logic [vec_pkg::VREG_IDX_W-1:0]    wr_dst,
  output logic [LANES*LANE_W-1:0]           wr_data
);

  import vec_pkg::*;

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  vload_state_t               state_reg;
  vload_state_t               state_next;
  logic [IDX_W-1:0]           idx_reg;
  logic [ADDR_W-1:0]          addr_reg;
  logic [VREG_IDX_W-1:0]      dst_reg;
  logic [ADDR_W-1:0]          stride_val;
  logic                       accept;
  logic                       lane_we;
  logic                       last_lane;

  assign accept    = (state_reg == VL_IDLE) && start;
  assign lane_we   = (state_reg == VL_FETCH) && mem_rdy;
  assign last_lane = (idx_reg == IDX_W'(LANES - 1));

`ifdef VLOAD_STRIDE_EN
  logic [ADDR_W-1:0] stride_reg;

  // Stride is captured together with the base address at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride_reg <= '0;
    end else if (accept) begin
      stride_reg <= stride;
    end
  end

  assign stride_val = stride_reg;
`else
  assign stride_val = ADDR_W'(1);
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= VL_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs (no path from mem_rdy to outputs).
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      VL_IDLE: begin
        if (start) begin
          state_next = VL_FETCH;
        end
      end
      VL_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = addr_reg;
        if (mem_rdy && last_lane) begin
          state_next = VL_WRITE;
        end
      end
      VL_WRITE: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        done       = 1'b1;
        state_next = VL_IDLE;
      end
      default: begin
        state_next = VL_IDLE;
      end
    endcase
  end

  // Lane counter, running address (base + idx*stride, wrapping) and latched dst.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg  <= '0;
      addr_reg <= '0;
      dst_reg  <= '0;
    end else if (accept) begin
      idx_reg  <= '0;
      addr_reg <= base_addr;
      dst_reg  <= dst;
    end else if (lane_we) begin
      idx_reg  <= idx_reg + IDX_W'(1);
      addr_reg <= addr_reg + stride_val;
    end
  end

  assign wr_dst = dst_reg;

  vector_lane_assembler #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .IDX_W  (IDX_W)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .lane_we   (lane_we),
    .lane_idx  (idx_reg),
    .lane_data (mem_data),
    .vec_out   (wr_data)
  );

endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench for vector_load_unit: directed scenarios with randomized
// memory contents, ready patterns and junk on non-latched inputs, checked
// against a lane-by-lane reference computed from the load rules.
module tb_vector_load_unit;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;
  localparam int ADDR_W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  base_addr;
`ifdef VLOAD_STRIDE_EN
  logic [15:0]  stride;
`endif
  logic [2:0]   dst;
  logic         busy;
  logic         done;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic         mem_rdy;
  logic [15:0]  mem_data;
  logic         wr_en;
  logic [2:0]   wr_dst;
  logic [255:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] seed = 16'h0000;

  always #5 clk = ~clk;

  vector_load_unit #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
`ifdef VLOAD_STRIDE_EN
    .stride    (stride),
`endif
    .dst       (dst),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdy   (mem_rdy),
    .mem_data  (mem_data),
    .wr_en     (wr_en),
    .wr_dst    (wr_dst),
    .wr_data   (wr_data)
  );

  // Memory image: with seed 0, address 0x0100+i holds 0x1000+i.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a + 16'h0F00) ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, "_addr"}, mem_addr, 16'h0000);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // One complete load. mode 0: always ready, 1: ready on even cycles, 2: random.
  // busy_starts pulses start with junk fields at cycles 3 and 10.
  task automatic run_load(input logic [15:0] base, input logic [2:0] d,
                          input logic [15:0] strd, input int mode, input bit busy_starts);
    logic [255:0] exp_vec;
    logic [15:0]  ea;
    int           acc;
    int           c;
    bit           fin;
    bit           rdy;
    for (int i = 0; i < LANES; i++) begin
      ea = base + 16'(i) * strd;
      exp_vec[i*16 +: 16] = mem_word(ea);
    end
    start     = 1'b1;
    base_addr = base;
    dst       = d;
`ifdef VLOAD_STRIDE_EN
    stride    = strd;
`endif
    mem_rdy   = 1'($urandom);
    mem_data  = 16'($urandom);
    tick;
    acc = 0;
    fin = 1'b0;
    for (c = 1; c <= 200 && !fin; c++) begin
      base_addr = 16'($urandom);
      dst       = 3'($urandom);
`ifdef VLOAD_STRIDE_EN
      stride    = 16'($urandom);
`endif
      start     = busy_starts && (c == 3 || c == 10);
      if (acc < LANES) begin
        ea = base + 16'(acc) * strd;
        chk("fetch_busy", busy, 1'b1);
        chk("fetch_rd_en", mem_rd_en, 1'b1);
        chk("fetch_wr_en", wr_en, 1'b0);
        chk("fetch_addr", mem_addr, ea);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (c % 2 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        mem_rdy  = rdy;
        mem_data = rdy ? mem_word(ea) : 16'($urandom);
        if (rdy) acc++;
      end else begin
        if (mode == 0) chk("write_cycle", c, 17);
        if (mode == 1) chk("write_cycle", c, 33);
        chk("write_wr_en", wr_en, 1'b1);
        chk("write_done", done, 1'b1);
        chk("write_busy", busy, 1'b1);
        chk("write_rd_en", mem_rd_en, 1'b0);
        chk("write_dst", wr_dst, d);
        chk("write_data", wr_data, exp_vec);
        mem_rdy = 1'b0;
        start   = 1'b0;
        fin     = 1'b1;
      end
      tick;
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $error("FAIL load_timeout: observed no write after 200 cycles, required write");
    end
    chk_idle("post_write");
    $display("load base=%h dst=%0d stride=%h mode=%0d busy_starts=%0d cycles=%0d",
             base, d, strd, mode, busy_starts, c - 1);
  endtask

  initial begin
    logic [15:0] one;
    one       = 16'h0001;
    rst       = 1'b1;
    start     = 1'b1;
    base_addr = 16'h1234;
    dst       = 3'd7;
`ifdef VLOAD_STRIDE_EN
    stride    = 16'h0001;
`endif
    mem_rdy   = 1'b1;
    mem_data  = 16'hFFFF;
    @(negedge clk);
    tick;
    tick;
    // Reset wins over a simultaneous start.
    chk_idle("reset");
    chk("reset_wr_data", wr_data, 256'd0);
    chk("reset_wr_dst", wr_dst, 3'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick;
    chk_idle("idle");
    $display("reset done");

    // Unit-stride load from 0x0100 into v5.
    run_load(16'h0100, 3'd5, one, 0, 1'b0);
    // Back-to-back start in the first IDLE cycle after WRITE.
    seed = 16'($urandom);
    run_load(16'($urandom), 3'($urandom), one, 0, 1'b0);
    // Stalled memory.
    run_load(16'h0300, 3'd2, one, 1, 1'b0);
    // Address wrap: lane 8 reads 0x0000.
    run_load(16'hFFF8, 3'd6, one, 0, 1'b0);
    // Starts while busy are ignored.
    run_load(16'h0400, 3'd1, one, 2, 1'b1);

    // Reset mid-FETCH: no write, buffer and fields cleared.
    start     = 1'b1;
    base_addr = 16'h0500;
    dst       = 3'd4;
    mem_rdy   = 1'b1;
    mem_data  = 16'hBEEF;
    tick;
    start = 1'b0;
    for (int c = 1; c < 9; c++) begin
      mem_data = mem_word(16'h0500 + 16'(c - 1));
      tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("abort");
    chk("abort_wr_data", wr_data, 256'd0);
    chk("abort_wr_dst", wr_dst, 3'd0);
    for (int c = 0; c < 24; c++) begin
      mem_rdy  = 1'($urandom);
      mem_data = 16'($urandom);
      chk("abort_no_wr", wr_en, 1'b0);
      tick;
    end
    $display("reset mid-fetch checked");
    mem_rdy = 1'b0;
    run_load(16'h0600, 3'd3, one, 0, 1'b0);

    // Randomized loads.
    for (int k = 0; k < 6; k++) begin
      seed = 16'($urandom);
      run_load(16'($urandom), 3'($urandom), one, 2, 1'($urandom));
    end

`ifdef VLOAD_STRIDE_EN
    seed = 16'h0000;
    run_load(16'h0200, 3'd0, 16'h0004, 0, 1'b0);
    run_load(16'h0200, 3'd7, 16'h0000, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      seed = 16'($urandom);
      run_load(16'($urandom), 3'($urandom), 16'($urandom), 2, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
